// File: rtl/m_fmd_code_tx_pkg.sv
// Shared definitions for the FMD code transmitter and the lock receiver bench.
// State encoding, default code and acknowledge masks live here.
package m_fmd_code_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_STROBE   = 3'd1,
      S_WAIT_ACK = 3'd2,
      S_GAP      = 3'd3,
      S_CONFIRM  = 3'd4,
      S_CHECK    = 3'd5,
      S_DONE     = 3'd6,
      S_FAIL     = 3'd7
   } state_t;

   localparam logic [27:0] DEF_CODE = 28'h8324403;
   localparam logic [7:0]  ACK_ALL  = 8'hFF;
   localparam logic [2:0]  LAST_K   = 3'd6;

   // Bits 0..k set: receiver has latched digits 0 through k.
   function automatic logic [7:0] ack_mask(input logic [2:0] k);
      logic [8:0] t;
      t = (9'd1 << (k + 3'd1)) - 9'd1;
      return t[7:0];
   endfunction

endpackage

// File: rtl/m_fmd_code_tx_if.sv
// Transmitter <-> lock receiver bundle.
// master = transmitter, slave = receiver side.
interface m_fmd_code_tx_if;

   logic       i_start;
   logic       i_abort;
   logic [7:0] iv_ack;
   logic [3:0] o_data;
   logic       o_set_data;
   logic       o_CE;
   logic       o_busy;
   logic       o_done;
   logic       o_pass;

   modport master (
      input  i_start, i_abort, iv_ack,
      output o_data, o_set_data, o_CE,
      output o_busy, o_done, o_pass
   );

   modport slave (
      output i_start, i_abort, iv_ack,
      input  o_data, o_set_data, o_CE,
      input  o_busy, o_done, o_pass
   );

endinterface

// File: rtl/m_fmd_code_tx_gap.sv
// Load / count-down idle-gap timer.
// o_zero flags the final gap cycle.
module m_fmd_gap_timer (
   input  logic       clk,
   input  logic       i_Rst,
   input  logic       i_load,
   input  logic       i_en,
   input  logic [3:0] i_val,
   output logic       o_zero
);

   logic [3:0] r_cnt;

   always_ff @(posedge clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_cnt <= 4'd0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_en && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/m_fmd_code_tx.sv
// Sends a 7-digit code to the lock receiver, one strobe per digit,
// checking the acknowledge vector after each strobe and at confirm.
module m_fmd_code_tx
   import m_fmd_code_tx_pkg::*;
#(
   parameter logic [27:0] CODE       = DEF_CODE,
   parameter int unsigned GAP_CYCLES = 2
) (
   input logic             clk,
   input logic             i_Rst,
   m_fmd_code_tx_if.master bus
);

   localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES - 1);

   state_t     r_state;
   logic [2:0] r_k;
   logic       r_last;
   logic [3:0] r_data;
   logic       r_set_n;
   logic       r_ce;
   logic       r_busy;
   logic       r_done;
   logic       r_pass;

   logic       w_load;
   logic       w_gap;
   logic       w_zero;
   logic       w_match;

   assign w_match = (bus.iv_ack == ack_mask(r_k));
   assign w_load  = (r_state == S_WAIT_ACK);
   assign w_gap   = (r_state == S_GAP);

   m_fmd_gap_timer u_gap (
      .clk    (clk),
      .i_Rst  (i_Rst),
      .i_load (w_load),
      .i_en   (w_gap),
      .i_val  (GAP_LD),
      .o_zero (w_zero)
   );

   // Outputs are set on entry to a state so they are valid for its cycle.
   always_ff @(posedge clk or posedge i_Rst) begin
      if (i_Rst) begin
         r_state <= S_IDLE;
         r_k     <= 3'd0;
         r_last  <= 1'b0;
         r_data  <= 4'd0;
         r_set_n <= 1'b1;
         r_ce    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         r_ce    <= 1'b0;
         r_set_n <= 1'b1;
         r_done  <= 1'b0;
         if ((r_state != S_IDLE) && bus.i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.i_start) begin
                     r_pass  <= 1'b0;
                     r_k     <= 3'd0;
                     r_last  <= 1'b0;
                     r_busy  <= 1'b1;
                     r_ce    <= 1'b1;
                     r_set_n <= 1'b0;
                     r_data  <= CODE[3:0];
                     r_state <= S_STROBE;
                  end
               end
               S_STROBE: r_state <= S_WAIT_ACK;
               S_WAIT_ACK: begin
                  if (!w_match) begin
                     r_done  <= 1'b1;
                     r_pass  <= 1'b0;
                     r_state <= S_FAIL;
                  end else begin
                     if (r_k == LAST_K) r_last <= 1'b1;
                     else               r_k    <= r_k + 3'd1;
                     r_state <= S_GAP;
                  end
               end
               S_GAP: begin
                  if (w_zero) begin
                     r_ce    <= 1'b1;
                     r_set_n <= 1'b0;
                     if (r_last) begin
                        r_data  <= 4'd0;
                        r_state <= S_CONFIRM;
                     end else begin
                        r_data  <= CODE[{r_k, 2'b00} +: 4];
                        r_state <= S_STROBE;
                     end
                  end
               end
               S_CONFIRM: r_state <= S_CHECK;
               S_CHECK: begin
                  r_done  <= 1'b1;
                  r_pass  <= (bus.iv_ack == ACK_ALL);
                  r_state <= (bus.iv_ack == ACK_ALL) ? S_DONE : S_FAIL;
               end
               S_DONE, S_FAIL: begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.o_data     = r_data;
   assign bus.o_set_data = r_set_n;
   assign bus.o_CE       = r_ce;
   assign bus.o_busy     = r_busy;
   assign bus.o_done     = r_done;
   assign bus.o_pass     = r_pass;

endmodule

// File: tb/tb_m_fmd_code_tx.sv
// Directed bench: four transmitters looped back to small receiver models.
// g[0] default, g[1] wrong code, g[2] gap 1, g[3] gap 15.
module tb_m_fmd_code_tx;
   import m_fmd_code_tx_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] start = '0;
   logic [3:0] abort = '0;
   logic [3:0] tamper = '0;
   int         cycn = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         s0 = 0;

   logic [3:0] exp_d [8] = '{4'h3, 4'h0, 4'h4, 4'h4,
                             4'h2, 4'h3, 4'h8, 4'h0};
   logic [7:0] exp_a [8] = '{8'h01, 8'h03, 8'h07, 8'h0F,
                             8'h1F, 8'h3F, 8'h7F, 8'hFF};

   always #5 clk = ~clk;
   always @(posedge clk) cycn <= cycn + 1;

   for (genvar i = 0; i < 4; i++) begin : g
      localparam logic [27:0] PC = (i == 1) ? 28'h8324409 : DEF_CODE;
      localparam int GP = (i == 2) ? 1 : ((i == 3) ? 15 : 2);

      m_fmd_code_tx_if bus ();

      m_fmd_code_tx #(.CODE(PC), .GAP_CYCLES(GP)) dut (
         .clk   (clk),
         .i_Rst (rst),
         .bus   (bus.master)
      );

      logic [27:0] rx_code;
      logic [7:0]  ack;
      logic [2:0]  ridx;
      logic        ok;

      assign rx_code     = DEF_CODE;
      assign bus.i_start = start[i];
      assign bus.i_abort = abort[i];
      assign bus.iv_ack  = tamper[i] ? 8'h00 : ack;

      // Receiver: one ack bit per digit, FF/00 verdict on confirm.
      always @(posedge clk or posedge rst) begin
         if (rst) begin
            ack  <= 8'h00;
            ridx <= 3'd0;
            ok   <= 1'b1;
         end else if (bus.o_CE && !bus.o_set_data) begin
            if (ridx == 3'd7) begin
               ack <= ok ? 8'hFF : 8'h00;
            end else begin
               ack[ridx] <= 1'b1;
               ok   <= ok && (bus.o_data == rx_code[{ridx, 2'b00} +: 4]);
               ridx <= ridx + 3'd1;
            end
         end
      end

      int         n_ce, n_done, n_ack, done_at, ce1, ce2;
      logic       pass_d, prev_ce;
      logic [3:0] dlog [8];
      logic [7:0] alog [8];

      always @(negedge clk) begin
         if (rst) begin
            n_ce    <= 0;
            n_done  <= 0;
            n_ack   <= 0;
            done_at <= -1;
            ce1     <= 0;
            ce2     <= 0;
            pass_d  <= 1'b0;
            prev_ce <= 1'b0;
         end else begin
            prev_ce <= bus.o_CE;
            if (bus.o_CE) begin
               if (n_ce < 8) dlog[n_ce] <= bus.o_data;
               if (n_ce == 0) ce1 <= cycn;
               if (n_ce == 1) ce2 <= cycn;
               n_ce <= n_ce + 1;
            end
            if (prev_ce) begin
               if (n_ack < 8) alog[n_ack] <= bus.iv_ack;
               n_ack <= n_ack + 1;
            end
            if (bus.o_done) begin
               n_done  <= n_done + 1;
               done_at <= cycn;
               pass_d  <= bus.o_pass;
            end
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_start(input logic [3:0] m);
      @(negedge clk);
      start = m;
      s0 = cycn;
      @(negedge clk);
      start = '0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_data", 32'(g[0].bus.o_data), 32'h0);
      chk("rst_set", 32'(g[0].bus.o_set_data), 32'h1);
      chk("rst_ce", 32'(g[0].bus.o_CE), 32'h0);
      chk("rst_busy", 32'(g[0].bus.o_busy), 32'h0);
      chk("rst_done", 32'(g[0].bus.o_done), 32'h0);
      chk("rst_pass", 32'(g[0].bus.o_pass), 32'h0);
      rst = 1'b0;

      // Full transfer on all four instances at once.
      pulse_start(4'hF);
      for (int w = 0; w < 200 && g[3].n_done == 0; w++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("p_done_cyc", 32'(g[0].done_at - s0), 32'd31);
      chk("p_ndone", 32'(g[0].n_done), 32'd1);
      chk("p_pass", 32'(g[0].pass_d), 32'h1);
      chk("p_pass_hold", 32'(g[0].bus.o_pass), 32'h1);
      chk("p_busy_end", 32'(g[0].bus.o_busy), 32'h0);
      chk("p_nce", 32'(g[0].n_ce), 32'd8);
      chk("p_space", 32'(g[0].ce2 - g[0].ce1), 32'd4);
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("p_dig%0d", j), 32'(g[0].dlog[j]), 32'(exp_d[j]));
         chk($sformatf("p_ack%0d", j), 32'(g[0].alog[j]), 32'(exp_a[j]));
      end
      chk("bad_done_cyc", 32'(g[1].done_at - s0), 32'd31);
      chk("bad_ndone", 32'(g[1].n_done), 32'd1);
      chk("bad_pass", 32'(g[1].pass_d), 32'h0);
      chk("bad_ack_chk", 32'(g[1].alog[7]), 32'h00);
      chk("bad_ack6", 32'(g[1].alog[6]), 32'h7F);
      chk("g1_space", 32'(g[2].ce2 - g[2].ce1), 32'd3);
      chk("g1_done_cyc", 32'(g[2].done_at - s0), 32'd24);
      chk("g1_pass", 32'(g[2].pass_d), 32'h1);
      chk("g15_space", 32'(g[3].ce2 - g[3].ce1), 32'd17);
      chk("g15_done_cyc", 32'(g[3].done_at - s0), 32'd122);
      chk("g15_pass", 32'(g[3].pass_d), 32'h1);
      chk("g15_nce", 32'(g[3].n_ce), 32'd8);

      // Abort in the gap following digit 3.
      do_reset();
      pulse_start(4'h1);
      repeat (14) @(negedge clk);
      chk("ab_busy_pre", 32'(g[0].bus.o_busy), 32'h1);
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      chk("ab_busy", 32'(g[0].bus.o_busy), 32'h0);
      chk("ab_set", 32'(g[0].bus.o_set_data), 32'h1);
      chk("ab_ce", 32'(g[0].bus.o_CE), 32'h0);
      chk("ab_pass", 32'(g[0].bus.o_pass), 32'h0);
      repeat (40) @(negedge clk);
      chk("ab_ndone", 32'(g[0].n_done), 32'd0);
      chk("ab_nce", 32'(g[0].n_ce), 32'd4);

      // Start+abort together in IDLE, then a stray start mid-transfer.
      do_reset();
      @(negedge clk);
      start[0] = 1'b1;
      abort[0] = 1'b1;
      s0 = cycn;
      @(negedge clk);
      start[0] = 1'b0;
      abort[0] = 1'b0;
      chk("sa_busy", 32'(g[0].bus.o_busy), 32'h1);
      chk("sa_ce", 32'(g[0].bus.o_CE), 32'h1);
      chk("sa_set", 32'(g[0].bus.o_set_data), 32'h0);
      chk("sa_data", 32'(g[0].bus.o_data), 32'h3);
      repeat (9) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      for (int w = 0; w < 60 && g[0].n_done == 0; w++) @(negedge clk);
      repeat (10) @(negedge clk);
      chk("rs_done_cyc", 32'(g[0].done_at - s0), 32'd31);
      chk("rs_ndone", 32'(g[0].n_done), 32'd1);
      chk("rs_nce", 32'(g[0].n_ce), 32'd8);
      chk("rs_pass", 32'(g[0].pass_d), 32'h1);

      // Wrong ack after the first strobe.
      do_reset();
      tamper[0] = 1'b1;
      pulse_start(4'h1);
      for (int w = 0; w < 20 && g[0].n_done == 0; w++) @(negedge clk);
      repeat (2) @(negedge clk);
      tamper[0] = 1'b0;
      chk("tm_done_cyc", 32'(g[0].done_at - s0), 32'd3);
      chk("tm_pass", 32'(g[0].pass_d), 32'h0);
      chk("tm_nce", 32'(g[0].n_ce), 32'd1);
      chk("tm_busy", 32'(g[0].bus.o_busy), 32'h0);

      // Asynchronous reset during a strobe.
      do_reset();
      pulse_start(4'h1);
      chk("ar_ce_pre", 32'(g[0].bus.o_CE), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("ar_ce", 32'(g[0].bus.o_CE), 32'h0);
      chk("ar_set", 32'(g[0].bus.o_set_data), 32'h1);
      chk("ar_busy", 32'(g[0].bus.o_busy), 32'h0);
      chk("ar_data", 32'(g[0].bus.o_data), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("ar_ndone", 32'(g[0].n_done), 32'd0);
      chk("ar_idle", 32'(g[0].bus.o_busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/m_fmd_code_tx.md
M_FMD_CODE_TX -- requirements
Module: m_fmd_code_tx

Interface
REQ-001 Parameter CODE, default 28'h8324403, seven 4-bit digits; nibble 0 is sent first (sequence 3,0,4,4,2,3,8).
REQ-002 Parameter GAP_CYCLES, default 2, range 1..15; idle cycles between strobes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_Rst  input  1  asynchronous, active-high reset.
REQ-005 i_start  input  1  request to send the full code; sampled only in IDLE.
REQ-006 i_abort  input  1  cancels a transfer in progress; returns to IDLE.
REQ-007 iv_ack  input  8  acknowledge vector returned by the lock receiver.
REQ-008 o_data  output  4  digit driven to the receiver's data input.
REQ-009 o_set_data  output  1  active-low digit-valid qualifier; 0 only during a strobe cycle.
REQ-010 o_CE  output  1  one-cycle clock-enable pulse to the receiver; high only during a strobe cycle.
REQ-011 o_busy  output  1  high in every state except IDLE.
REQ-012 o_done  output  1  one-cycle pulse when a transfer ends in DONE or FAIL.
REQ-013 o_pass  output  1  1 when the last transfer completed with iv_ack == 8'hFF; held until the next accepted i_start.

Function
REQ-014 States: IDLE, STROBE, WAIT_ACK, GAP, CONFIRM, CHECK, DONE, FAIL; binary encoding, 3 bits.
REQ-015 IDLE with i_start=1: clear o_pass, set digit index k=0, enter STROBE next cycle.
REQ-016 STROBE (one cycle): o_data=CODE[4k+3:4k], o_set_data=0, o_CE=1; next state WAIT_ACK.
REQ-017 WAIT_ACK (one cycle): o_set_data=1, o_CE=0, o_data holds; compare iv_ack to expected mask (2^(k+1))-1, i.e. bits 0..k set, all others clear.
REQ-018 WAIT_ACK mismatch: go to FAIL; match with k<6: increment k, go to GAP; match with k=6: go to GAP, then CONFIRM.
REQ-019 GAP: o_set_data=1, o_CE=0 for exactly GAP_CYCLES cycles, counted by a 4-bit gap counter; then STROBE (k<=6) or CONFIRM (after digit 6).
REQ-020 CONFIRM (one cycle): o_data=0, o_set_data=0, o_CE=1; next state CHECK.
REQ-021 CHECK: iv_ack==8'hFF goes to DONE; any other value goes to FAIL.
REQ-022 DONE: o_done=1 and o_pass=1 for one cycle, then IDLE; o_pass remains 1.
REQ-023 FAIL: o_done=1 and o_pass=0 for one cycle, then IDLE.
REQ-024 i_abort=1 in any non-IDLE state: next state IDLE, o_set_data=1, o_CE=0, no o_done pulse, o_pass=0; i_abort has priority over every other transition.
REQ-025 i_start while busy is ignored; i_start and i_abort asserted together in IDLE: i_start wins (abort has nothing to cancel).
REQ-026 Digit index k never exceeds 6; it does not wrap.
REQ-027 Latency from accepted i_start to o_done on a pass: 8 strobes + 8 check cycles + 7*GAP_CYCLES + DONE cycle, measured to the o_done cycle (31 cycles at default).
REQ-028 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-029 i_Rst=1 asynchronously forces IDLE, k=0, gap counter=0, o_data=0, o_set_data=1, o_CE=0, o_busy=0, o_done=0, o_pass=0.
REQ-030 Reset asserted mid-transfer aborts without an o_done pulse; after release the block waits for a new i_start.

Structure
REQ-031 State encoding localparams, the default CODE, and the 8'hFF complete mask belong in a shared package, also used by the lock receiver testbench.
REQ-032 The gap counter is a natural sub-module, m_fmd_gap_timer (load, count-down, zero flag); all other logic stays in one module.

Verification
REQ-033 Loopback to the lock receiver (receiver reset released, CE/set_data/data wired): i_start pulse -> digits 3,0,4,4,2,3,8 appear on the o_CE cycles, iv_ack steps 01,03,07,0F,1F,3F,7F,FF, o_done at cycle 31, o_pass=1.
REQ-034 CODE=28'h8324409 against the default receiver -> FAIL after 7th strobe, iv_ack=8'h00 at check, o_done=1, o_pass=0.
REQ-035 i_abort asserted in the GAP after digit 3 -> IDLE next cycle, o_set_data=1, o_CE=0, no o_done, o_busy=0.
REQ-036 i_start re-pulsed during a transfer -> strobe count and timing unchanged, single o_done.
REQ-037 i_Rst asserted during STROBE -> o_CE=0 and o_set_data=1 immediately, without waiting for a clock edge; all outputs at reset values.
REQ-038 GAP_CYCLES=1 and GAP_CYCLES=15 -> strobe spacing of 3 and 17 cycles respectively; pass result unchanged.
